// File: rtl/fwd_hazard_d.sv
// Decode-stage forwarding-select and load-use stall unit with stall statistics.
// Define FWD_HAZARD_D_STATS_EN to build the saturating stall_cnt counter; otherwise stall_cnt is tied to 0.
module fwd_hazard_d #(
   parameter int AW   = 5,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [5:0]      opcode_d,
   input  logic [5:0]      funct_d,
   input  logic [AW-1:0]   rs_d,
   input  logic [AW-1:0]   rt_d,
   input  logic            regwrite_e,
   input  logic            memread_e,
   input  logic [AW-1:0]   rd_e,
   input  logic            regwrite_m,
   input  logic            memread_m,
   input  logic [AW-1:0]   rd_m,
   input  logic            regwrite_w,
   input  logic [AW-1:0]   rd_w,
   input  logic            flush,
   output logic [1:0]      fwd_a_d,
   output logic [1:0]      fwd_b_d,
   output logic            stall_d,
   output logic [CNTW-1:0] stall_cnt,
   output logic            dbg_state
);

   typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

   state_t state;
   logic   hcnt;
   logic   hcnt_dec;

   logic is_jr, is_jalr, is_beq, is_bne, use_a, use_b;
   logic a_e, a_m, a_w, b_e, b_m, b_w;
   logic [1:0] need_a, need_b, need;

   // Register 0 is hardwired, so a write to it is never a real producer.
   function automatic logic hit(input logic we, input logic [AW-1:0] rd, input logic [AW-1:0] src);
      return we && (rd == src) && (src != '0);
   endfunction

   function automatic logic [1:0] sel(input logic used, input logic hm, input logic hw);
      if (!used)                  return 2'b00;
      else if (hm && !memread_m)  return 2'b01;
      else if (hw)                return 2'b10;
      else                        return 2'b00;
   endfunction

   // 2 = load still in EX (two bubbles), 1 = one more cycle before a forwardable value exists.
   function automatic logic [1:0] need_of(input logic used, input logic he, input logic hm);
      if (!used)                 return 2'd0;
      else if (he && memread_e)  return 2'd2;
      else if (he)               return 2'd1;
      else if (hm && memread_m)  return 2'd1;
      else                       return 2'd0;
   endfunction

   always_comb begin
      is_jr   = (opcode_d == 6'b000000) && (funct_d == 6'b001000);
      is_jalr = (opcode_d == 6'b000000) && (funct_d == 6'b001001);
      is_beq  = (opcode_d == 6'b000100);
      is_bne  = (opcode_d == 6'b000101);
      use_a   = is_jr || is_jalr || is_beq || is_bne;
      use_b   = is_beq || is_bne;

      a_e = hit(regwrite_e, rd_e, rs_d);
      a_m = hit(regwrite_m, rd_m, rs_d);
      a_w = hit(regwrite_w, rd_w, rs_d);
      b_e = hit(regwrite_e, rd_e, rt_d);
      b_m = hit(regwrite_m, rd_m, rt_d);
      b_w = hit(regwrite_w, rd_w, rt_d);

      need_a = need_of(use_a, a_e, a_m);
      need_b = need_of(use_b, b_e, b_m);
      need   = (need_a > need_b) ? need_a : need_b;
   end

   always_comb begin
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
      stall_d = 1'b0;
      if (!rst) begin
         fwd_a_d = sel(use_a, a_m, a_w);
         fwd_b_d = sel(use_b, b_m, b_w);
         if (!flush)
            stall_d = (state == HOLD) ? 1'b1 : (need != 2'd0);
      end
   end

   assign hcnt_dec  = hcnt - 1'b1;
   assign dbg_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         hcnt  <= 1'b0;
      end else if (flush) begin
         state <= RUN;
         hcnt  <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (need == 2'd2) begin
                  state <= HOLD;
                  hcnt  <= 1'b1;
               end
            end
            HOLD: begin
               hcnt <= hcnt_dec;
               if (hcnt_dec == 1'b0)
                  state <= RUN;
            end
            default: begin
               state <= RUN;
               hcnt  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FWD_HAZARD_D_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall_d && (stall_cnt != {CNTW{1'b1}}))
         stall_cnt <= stall_cnt + 1'b1;
   end
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_d.sv
// Directed bench for fwd_hazard_d: forwarding selects, load-use stall/HOLD, flush, reset and stall statistics.
module tb_fwd_hazard_d;

   localparam int AW   = 5;
   localparam int CNTW = 16;

`ifdef FWD_HAZARD_D_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [5:0]      opcode_d, funct_d;
   logic [AW-1:0]   rs_d, rt_d, rd_e, rd_m, rd_w;
   logic            regwrite_e, memread_e, regwrite_m, memread_m, regwrite_w, flush;
   logic [1:0]      fwd_a_d, fwd_b_d;
   logic            stall_d;
   logic [CNTW-1:0] stall_cnt;
   logic            dbg_state;

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;
   int max_cnt = (1 << CNTW) - 1;

   fwd_hazard_d #(.AW(AW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst),
      .opcode_d(opcode_d), .funct_d(funct_d), .rs_d(rs_d), .rt_d(rt_d),
      .regwrite_e(regwrite_e), .memread_e(memread_e), .rd_e(rd_e),
      .regwrite_m(regwrite_m), .memread_m(memread_m), .rd_m(rd_m),
      .regwrite_w(regwrite_w), .rd_w(rd_w), .flush(flush),
      .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .stall_d(stall_d),
      .stall_cnt(stall_cnt), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic clear();
      opcode_d = 6'h3f; funct_d = 6'h00; rs_d = '0; rt_d = '0;
      regwrite_e = 0; memread_e = 0; rd_e = '0;
      regwrite_m = 0; memread_m = 0; rd_m = '0;
      regwrite_w = 0; rd_w = '0; flush = 0;
   endtask

   task automatic op_jr();   opcode_d = 6'b000000; funct_d = 6'b001000; endtask
   task automatic op_jalr(); opcode_d = 6'b000000; funct_d = 6'b001001; endtask
   task automatic op_beq();  opcode_d = 6'b000100; funct_d = 6'b000000; endtask
   task automatic op_bne();  opcode_d = 6'b000101; funct_d = 6'b000000; endtask

   // Advance one cycle; the counter model steps on the rising edge when a stall was expected.
   task automatic tick(input logic exp_stall);
      if (STATS && exp_stall && exp_cnt < max_cnt) exp_cnt++;
      @(negedge clk);
      #1;
   endtask

   task automatic check_cnt(input string tag);
      check(tag, 32'(stall_cnt), 32'(exp_cnt));
   endtask

   initial begin
      clear();
      rst = 1'b1;
      // Hazard and forwarding inputs present while in reset must be masked.
      op_beq(); rs_d = 5'd3; rt_d = 5'd4;
      regwrite_e = 1; memread_e = 1; rd_e = 5'd4;
      regwrite_m = 1; rd_m = 5'd3;
      @(negedge clk); #1;
      check("rst_stall", 32'(stall_d), 0);
      check("rst_fwd_a", 32'(fwd_a_d), 0);
      check("rst_state", 32'(dbg_state), 0);
      check_cnt("rst_cnt");
      clear();
      rst = 1'b0;
      tick(0);

      // jr: MEM forward on A, B unused.
      op_jr(); rs_d = 5'd8; rt_d = 5'd8; regwrite_m = 1; rd_m = 5'd8; #1;
      check("jr_fwd_a", 32'(fwd_a_d), 32'b01);
      check("jr_fwd_b_unused", 32'(fwd_b_d), 0);
      check("jr_stall", 32'(stall_d), 0);
      tick(0);

      // jr: WB-only match.
      clear(); op_jr(); rs_d = 5'd9; regwrite_w = 1; rd_w = 5'd9; #1;
      check("jr_fwd_a_wb", 32'(fwd_a_d), 32'b10);
      tick(0);

      // bne: MEM beats WB on B.
      clear(); op_bne(); rs_d = 5'd1; rt_d = 5'd5;
      regwrite_m = 1; rd_m = 5'd5; regwrite_w = 1; rd_w = 5'd5; #1;
      check("bne_fwd_b_prio", 32'(fwd_b_d), 32'b01);
      check("bne_fwd_a", 32'(fwd_a_d), 0);
      tick(0);

      // jalr on r0: never forwarded, never stalls.
      clear(); op_jalr(); rs_d = 5'd0; regwrite_e = 1; rd_e = 5'd0;
      regwrite_w = 1; rd_w = 5'd0; #1;
      check("r0_stall", 32'(stall_d), 0);
      check("r0_fwd_a", 32'(fwd_a_d), 0);
      tick(0);

      // Non-branch opcode with a load-use match: no hazard.
      clear(); opcode_d = 6'b000000; funct_d = 6'b100000; rs_d = 5'd7;
      regwrite_e = 1; memread_e = 1; rd_e = 5'd7; #1;
      check("alu_no_stall", 32'(stall_d), 0);
      tick(0);

      // ALU result in EX: one stall, stays RUN.
      clear(); op_beq(); rs_d = 5'd3; regwrite_e = 1; rd_e = 5'd3; #1;
      check("ex_alu_stall", 32'(stall_d), 1);
      tick(1);
      check("ex_alu_state_run", 32'(dbg_state), 0);
      clear(); #1;
      check("ex_alu_release", 32'(stall_d), 0);
      check_cnt("ex_alu_cnt");
      tick(0);

      // Load in MEM: one stall, WB mux not used for the loaded reg.
      clear(); op_beq(); rs_d = 5'd6; regwrite_m = 1; memread_m = 1; rd_m = 5'd6; #1;
      check("mem_load_stall", 32'(stall_d), 1);
      check("mem_load_fwd_a", 32'(fwd_a_d), 0);
      tick(1);
      check("mem_load_state_run", 32'(dbg_state), 0);
      clear(); tick(0);

      // Load in EX: RUN stall, HOLD stall, then RUN.
      clear(); op_beq(); rs_d = 5'd3; rt_d = 5'd4; regwrite_e = 1; memread_e = 1; rd_e = 5'd4; #1;
      check("lu_c1_stall", 32'(stall_d), 1);
      check("lu_c1_state", 32'(dbg_state), 0);
      tick(1);
      check("lu_c2_state", 32'(dbg_state), 1);
      clear(); #1;
      check("lu_c2_hold_stall", 32'(stall_d), 1);
      tick(1);
      check("lu_c3_state", 32'(dbg_state), 0);
      check("lu_c3_stall", 32'(stall_d), 0);
      check_cnt("lu_cnt");
      tick(0);

      // Flush in RUN cancels the stall and the HOLD entry.
      clear(); op_beq(); rt_d = 5'd4; regwrite_e = 1; memread_e = 1; rd_e = 5'd4; flush = 1; #1;
      check("flush_run_stall", 32'(stall_d), 0);
      tick(0);
      check("flush_run_state", 32'(dbg_state), 0);
      clear(); tick(0);

      // Flush in HOLD.
      clear(); op_beq(); rt_d = 5'd4; regwrite_e = 1; memread_e = 1; rd_e = 5'd4; #1;
      tick(1);
      flush = 1; #1;
      check("flush_hold_stall", 32'(stall_d), 0);
      tick(0);
      check("flush_hold_next_state", 32'(dbg_state), 0);
      clear(); #1;
      check("flush_hold_next_stall", 32'(stall_d), 0);
      check_cnt("flush_cnt");
      tick(0);

      // Asynchronous reset in the middle of HOLD.
      clear(); op_beq(); rs_d = 5'd3; rt_d = 5'd4; regwrite_e = 1; memread_e = 1; rd_e = 5'd4;
      regwrite_m = 1; rd_m = 5'd3; #1;
      check("rh_fwd_a", 32'(fwd_a_d), 32'b01);
      tick(1);
      check("rh_in_hold", 32'(dbg_state), 1);
      #1 rst = 1'b1; #1;
      exp_cnt = 0;
      check_cnt("rh_cnt_async");
      check("rh_state_async", 32'(dbg_state), 0);
      check("rh_stall", 32'(stall_d), 0);
      check("rh_fwd_a_masked", 32'(fwd_a_d), 0);
      @(negedge clk);
      rst = 1'b0; #1;
      check("rh_post_state", 32'(dbg_state), 0);
      check("rh_post_stall", 32'(stall_d), 1);
      clear(); #1;
      tick(0);

      // Continuous stall for 2^CNTW+3 cycles.
      clear(); op_beq(); rs_d = 5'd6; regwrite_m = 1; memread_m = 1; rd_m = 5'd6; #1;
      for (int i = 0; i < (1 << CNTW) + 3; i++) begin
         tick(1);
         if (i == 2) check_cnt("sat_early");
      end
      check("sat_stall_still", 32'(stall_d), 1);
      check_cnt("sat_final");
      if (STATS) check("sat_all_ones", 32'(stall_cnt), 32'(max_cnt));
      tick(1);
      check_cnt("sat_hold");
      clear(); tick(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_d.md
FWD_HAZARD_D -- requirements
Module: fwd_hazard_d

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter CNTW, default 16, stall-statistics counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 opcode_d  in  6  decode-stage opcode.
REQ-006 funct_d  in  6  decode-stage funct field.
REQ-007 rs_d, rt_d  in  AW each  decode-stage source registers A and B.
REQ-008 regwrite_e, memread_e  in  1 each; rd_e  in  AW  EX-stage producer.
REQ-009 regwrite_m, memread_m  in  1 each; rd_m  in  AW  MEM-stage producer.
REQ-010 regwrite_w  in  1; rd_w  in  AW  WB-stage producer.
REQ-011 flush  in  1  decode-stage squash; cancels any stall.
REQ-012 fwd_a_d, fwd_b_d  out  2 each  operand select: 00 regfile, 01 MEM result, 10 WB result.
REQ-013 stall_d  out  1  freeze PC/IF-ID and bubble ID-EX.
REQ-014 stall_cnt  out  CNTW  saturating count of stall cycles.

Function
REQ-015 Decode: jr = opcode 000000 & funct 001000; jalr = opcode 000000 & funct 001001; beq = 000100; bne = 000101.
REQ-016 use_a = jr|jalr|beq|bne; use_b = beq|bne; unused source: fwd select 00, no hazard contribution.
REQ-017 match_X(src) = regwrite_X & (rd_X == src) & (src != 0), for X in {e,m,w}.
REQ-018 Forward select, per used source, combinational: 01 if match_m & !memread_m; else 10 if match_w; else 00; MEM beats WB on simultaneous match.
REQ-019 Need per source: 2 if match_e & memread_e; 1 if match_e & !memread_e; 1 if match_m & memread_m; else 0; need = max over used sources.
REQ-020 FSM states RUN, HOLD; 1-bit hold counter hcnt.
REQ-021 RUN: stall_d = (need != 0) & !flush, combinational, same cycle; need==2 & !flush -> HOLD, hcnt=1; otherwise stay RUN.
REQ-022 HOLD: stall_d = !flush regardless of producer inputs; hcnt decrements; hcnt==0 after decrement -> RUN, where hazard re-evaluated next cycle.
REQ-023 flush in any state: stall_d=0 that cycle, next state RUN, hcnt=0.
REQ-024 Forward selects valid in every state; during stall they reflect current inputs.
REQ-025 stall_cnt increments by 1 each cycle stall_d=1; holds at all-ones (saturate, no wrap).
REQ-026 Register 0 never forwarded, never stalls.

Reset
REQ-027 rst asserted: state RUN, hcnt=0, stall_cnt=0 immediately, independent of clk.
REQ-028 While rst high: stall_d=0, fwd_a_d=fwd_b_d=00.
REQ-029 rst mid-HOLD aborts hold; first cycle after release evaluates in RUN.

Configuration
REQ-030 Macro FWD_HAZARD_D_STATS_EN defined: stall_cnt counter implemented per REQ-025.
REQ-031 Macro undefined: no counter registers; stall_cnt tied to 0; all other behaviour identical.

Verification
REQ-032 jr, rs_d=8, regwrite_m=1, memread_m=0, rd_m=8 -> fwd_a_d=01, stall_d=0.
REQ-033 beq, rs_d=3, rt_d=4, regwrite_e=1, memread_e=1, rd_e=4 -> stall_d=1 two consecutive cycles (RUN then HOLD), RUN on third; stall_cnt +2.
REQ-034 bne, rt_d=5, rd_m=5 and rd_w=5 both writing, memread_m=0 -> fwd_b_d=01 (MEM priority).
REQ-035 jalr, rs_d=0, rd_e=0, regwrite_e=1 -> stall_d=0, fwd_a_d=00.
REQ-036 Load-use hazard entering HOLD, flush=1 in HOLD cycle -> stall_d=0 that cycle, RUN next; rst pulse mid-HOLD -> stall_cnt=0 asynchronously.
REQ-037 Force stall_d=1 for 2^CNTW+3 cycles with macro defined -> stall_cnt all-ones; macro undefined -> stall_cnt=0 throughout.
